// File: rtl/execute_mdu_if.sv
// EX-stage bundle between the ID/EX register and the execute/MDU block.
// op_valid_e is the valid; stall_e is the inverse of ready: an instruction leaves EX in any cycle with op_valid_e && !stall_e, and HI/LO side effects happen only when it is also !flush_e && !mdu_busy_e.
interface execute_mdu_if #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 3,
    parameter int SEL_W  = $clog2(FWD_N + 1)
);
    logic                    op_valid_e;
    logic                    flush_e;
    logic [5:0]              alu_control_e;
    logic [DATA_W-1:0]       read_data1_e;
    logic [DATA_W-1:0]       read_data2_e;
    logic [DATA_W-1:0]       sign_extend_data_out_e;
    logic                    alu_src_b_sel_e;
    logic [4:0]              alu_shamt_e;
    logic [4:0]              rt_e;
    logic [4:0]              rd_e;
    logic                    reg_file_write_addr_sel_e;
    logic [SEL_W-1:0]        forward_a_sel_e;
    logic [SEL_W-1:0]        forward_b_sel_e;
    logic [FWD_N*DATA_W-1:0] fwd_data_e;

    logic [DATA_W-1:0]       alu_result_e;
    logic                    alu_zero_e;
    logic                    alu_overflow_e;
    logic [DATA_W-1:0]       write_data2_e;
    logic [4:0]              reg_file_write_addr_e;
    logic [DATA_W-1:0]       hi_e;
    logic [DATA_W-1:0]       lo_e;
    logic                    mdu_busy_e;
    logic                    stall_e;

    modport master (
        output op_valid_e, flush_e, alu_control_e, read_data1_e, read_data2_e,
               sign_extend_data_out_e, alu_src_b_sel_e, alu_shamt_e, rt_e, rd_e,
               reg_file_write_addr_sel_e, forward_a_sel_e, forward_b_sel_e, fwd_data_e,
        input  alu_result_e, alu_zero_e, alu_overflow_e, write_data2_e,
               reg_file_write_addr_e, hi_e, lo_e, mdu_busy_e, stall_e
    );

    modport slave (
        input  op_valid_e, flush_e, alu_control_e, read_data1_e, read_data2_e,
               sign_extend_data_out_e, alu_src_b_sel_e, alu_shamt_e, rt_e, rd_e,
               reg_file_write_addr_sel_e, forward_a_sel_e, forward_b_sel_e, fwd_data_e,
        output alu_result_e, alu_zero_e, alu_overflow_e, write_data2_e,
               reg_file_write_addr_e, hi_e, lo_e, mdu_busy_e, stall_e
    );
endinterface

// File: rtl/execute_mdu.sv
// MIPS execute stage: operand bypass, single-cycle ALU, and an iterative
// multiply/divide unit that owns HI/LO and stalls dependent HI/LO ops.
module execute_mdu #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 3,
    parameter int SEL_W  = $clog2(FWD_N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    execute_mdu_if.slave ex,
    output logic         mdu_state_dbg
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [5:0] OP_ADD  = 6'b100000, OP_ADDU = 6'b100001;
    localparam logic [5:0] OP_SUB  = 6'b100010, OP_SUBU = 6'b100011;
    localparam logic [5:0] OP_AND  = 6'b100100, OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110, OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SLT  = 6'b101010, OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_SLL  = 6'b000000, OP_SRL  = 6'b000010, OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SLLV = 6'b000100, OP_SRLV = 6'b000110, OP_SRAV = 6'b000111;
    localparam logic [5:0] OP_MFHI = 6'b010000, OP_MTHI = 6'b010001;
    localparam logic [5:0] OP_MFLO = 6'b010010, OP_MTLO = 6'b010011;
    localparam logic [5:0] OP_MULT = 6'b011000, OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV  = 6'b011010, OP_DIVU  = 6'b011011;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  hi_q, lo_q, acc_hi_q, acc_lo_q, b_mag_q;
    logic               is_div_q, neg_q, rem_neg_q;

    logic [DATA_W-1:0]  src_a, fwd_b, src_b, sum, diff;
    logic               is_mdu_op, is_hilo_op, busy, accept;
    logic               a_neg, b_neg;
    logic [DATA_W-1:0]  a_mag, b_mag;
    logic [DATA_W:0]    mul_sum;
    logic [DATA_W+1:0]  div_trial;
    logic [DATA_W-1:0]  step_hi, step_lo, fin_hi, fin_lo;
    logic [2*DATA_W-1:0] mul_prod;
    logic               last_iter;

    // Select 0 and any select beyond FWD_N fall through to register-file data.
    always_comb begin
        src_a = ex.read_data1_e;
        fwd_b = ex.read_data2_e;
        for (int k = 1; k <= FWD_N; k++) begin
            if (ex.forward_a_sel_e == SEL_W'(k)) src_a = ex.fwd_data_e[(k-1)*DATA_W +: DATA_W];
            if (ex.forward_b_sel_e == SEL_W'(k)) fwd_b = ex.fwd_data_e[(k-1)*DATA_W +: DATA_W];
        end
    end

    assign src_b = ex.alu_src_b_sel_e ? ex.sign_extend_data_out_e : fwd_b;
    assign sum   = src_a + src_b;
    assign diff  = src_a - src_b;

    assign is_mdu_op  = ex.alu_control_e inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    assign is_hilo_op = is_mdu_op || (ex.alu_control_e inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO});
    assign busy       = (state_q == RUN);
    assign accept     = ex.op_valid_e && !ex.flush_e && !busy;

    always_comb begin
        ex.alu_result_e   = '0;
        ex.alu_overflow_e = 1'b0;
        case (ex.alu_control_e)
            OP_ADD: begin
                ex.alu_result_e   = sum;
                ex.alu_overflow_e = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (sum[DATA_W-1] != src_a[DATA_W-1]);
            end
            OP_ADDU: ex.alu_result_e = sum;
            OP_SUB: begin
                ex.alu_result_e   = diff;
                ex.alu_overflow_e = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (diff[DATA_W-1] != src_a[DATA_W-1]);
            end
            OP_SUBU: ex.alu_result_e = diff;
            OP_AND:  ex.alu_result_e = src_a & src_b;
            OP_OR:   ex.alu_result_e = src_a | src_b;
            OP_XOR:  ex.alu_result_e = src_a ^ src_b;
            OP_NOR:  ex.alu_result_e = ~(src_a | src_b);
            OP_SLT:  ex.alu_result_e = {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: ex.alu_result_e = {{(DATA_W-1){1'b0}}, src_a < src_b};
            OP_SLL:  ex.alu_result_e = src_b << ex.alu_shamt_e;
            OP_SRL:  ex.alu_result_e = src_b >> ex.alu_shamt_e;
            OP_SRA:  ex.alu_result_e = $signed(src_b) >>> ex.alu_shamt_e;
            OP_SLLV: ex.alu_result_e = src_b << src_a[SH_W-1:0];
            OP_SRLV: ex.alu_result_e = src_b >> src_a[SH_W-1:0];
            OP_SRAV: ex.alu_result_e = $signed(src_b) >>> src_a[SH_W-1:0];
            OP_MFHI: ex.alu_result_e = hi_q;
            OP_MFLO: ex.alu_result_e = lo_q;
            default: ex.alu_result_e = '0;
        endcase
    end

    assign ex.alu_zero_e            = (ex.alu_result_e == '0);
    assign ex.write_data2_e         = fwd_b;
    assign ex.reg_file_write_addr_e = ex.reg_file_write_addr_sel_e ? ex.rt_e : ex.rd_e;
    assign ex.hi_e                  = hi_q;
    assign ex.lo_e                  = lo_q;
    assign ex.mdu_busy_e            = busy;
    assign ex.stall_e               = ex.op_valid_e && !ex.flush_e && busy && is_hilo_op;
    assign mdu_state_dbg            = busy;

    // Both units work on magnitudes; signs are restored on the last iteration.
    // A zero divisor forces a positive quotient so the restoring loop yields all ones.
    assign a_neg = !ex.alu_control_e[0] && src_a[DATA_W-1];
    assign b_neg = !ex.alu_control_e[0] && fwd_b[DATA_W-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -fwd_b : fwd_b;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : '0);
    assign div_trial = {1'b0, acc_hi_q, acc_lo_q[DATA_W-1]} - {2'b00, b_mag_q};
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        if (!is_div_q) begin
            {step_hi, step_lo} = {mul_sum, acc_lo_q[DATA_W-1:1]};
        end else if (div_trial[DATA_W+1]) begin
            step_hi = {acc_hi_q[DATA_W-2:0], acc_lo_q[DATA_W-1]};
            step_lo = {acc_lo_q[DATA_W-2:0], 1'b0};
        end else begin
            step_hi = div_trial[DATA_W-1:0];
            step_lo = {acc_lo_q[DATA_W-2:0], 1'b1};
        end
    end

    always_comb begin
        mul_prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        if (is_div_q) begin
            fin_lo = neg_q ? -step_lo : step_lo;
            fin_hi = rem_neg_q ? -step_hi : step_hi;
        end else begin
            {fin_hi, fin_lo} = mul_prod;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_mdu_op) state_d = RUN;
            RUN:     if (last_iter) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            b_mag_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (busy) begin
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    hi_q <= fin_hi;
                    lo_q <= fin_lo;
                end
            end else if (accept) begin
                if (is_mdu_op) begin
                    acc_hi_q  <= '0;
                    acc_lo_q  <= a_mag;
                    b_mag_q   <= b_mag;
                    cnt_q     <= '0;
                    is_div_q  <= ex.alu_control_e[1];
                    neg_q     <= (a_neg ^ b_neg) && (fwd_b != '0);
                    rem_neg_q <= a_neg;
                end
                if (ex.alu_control_e == OP_MTHI) hi_q <= src_a;
                if (ex.alu_control_e == OP_MTLO) lo_q <= src_a;
            end
        end
    end
endmodule

// File: doc/execute_mdu.md
# execute_mdu

Parametrised execute stage for the pipelined MIPS core: per-operand forwarding over a configurable number of bypass sources, a single-cycle integer ALU, and an iterative multiply/divide unit (MDU) owning the HI/LO registers. Sits between the ID/EX and EX/MEM pipeline registers. Its stall output holds IF/ID/EX while an HI/LO-dependent instruction waits on a busy MDU.

## Interface
- DATA_W, 32: datapath width, even, ≥ 8.
- FWD_N, 3: number of bypass sources.
- SEL_W, $clog2(FWD_N+1): forward-select width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid_e  in  1  EX holds a real instruction.
- flush_e  in  1  EX instruction is cancelled this cycle.
- alu_control_e  in  6  operation (MIPS funct encoding, below).
- read_data1_e, read_data2_e  in  DATA_W  register-file operands rs/rt.
- sign_extend_data_out_e  in  DATA_W  immediate.
- alu_src_b_sel_e  in  1  0: forwarded rt, 1: immediate.
- alu_shamt_e  in  5  shift amount for constant shifts.
- rt_e, rd_e  in  5  destination candidates.
- reg_file_write_addr_sel_e  in  1  0: rd, 1: rt.
- forward_a_sel_e, forward_b_sel_e  in  SEL_W  0: register data; k: source k-1.
- fwd_data_e  in  FWD_N*DATA_W  bypass sources, source k at bits [k*DATA_W +: DATA_W].
- alu_result_e  out  DATA_W  result (incl. MFHI/MFLO).
- alu_zero_e  out  1  alu_result_e == 0.
- alu_overflow_e  out  1  signed overflow on ADD/SUB.
- write_data2_e  out  DATA_W  forwarded rt (store data).
- reg_file_write_addr_e  out  5  selected destination.
- hi_e, lo_e  out  DATA_W  current HI/LO registers.
- mdu_busy_e  out  1  MDU iterating.
- stall_e  out  1  hold EX and upstream stages.

## Operation
- Forwarding: src_a = mux(forward_a_sel_e), fwd_b likewise; select > FWD_N yields register data. src_b = alu_src_b_sel_e ? immediate : fwd_b. write_data2_e = fwd_b.
- ALU ops (combinational): ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 (signed), SLTU 101011, SLL 000000, SRL 000010, SRA 000011 (shift src_b by alu_shamt_e), SLLV 000100, SRLV 000110, SRAV 000111 (shift src_b by src_a[$clog2(DATA_W)-1:0]). Undefined codes: result 0.
- alu_overflow_e only on ADD/SUB, else 0. Wrap-around, no trap.
- HI/LO ops: MFHI 010000 / MFLO 010010 output HI/LO; MTHI 010001 / MTLO 010011 write src_a; MULT 011000, MULTU 011001, DIV 011010, DIVU 011011 start MDU on src_a, fwd_b.
- Accept = op_valid_e & !flush_e & !mdu_busy_e. MDU ops and MTHI/MTLO take effect only on accept.
- stall_e = op_valid_e & !flush_e & mdu_busy_e & (op is any HI/LO op). ALU ops never stall.
- FSM: IDLE -> (MDU op accepted) RUN; RUN counts DATA_W iterations (radix-2 shift-add multiply, restoring divide on magnitudes), then writes HI/LO and returns to IDLE.
- MULT: {HI,LO} = 2*DATA_W signed product; MULTU unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend; DIVU unsigned. Divide by zero: LO = all ones, HI = dividend. Most-negative / -1: LO = most-negative, HI = 0.
- flush_e never aborts an MDU op already in RUN.

## Timing
- Reset (async, any state incl. RUN): HI = LO = 0, FSM IDLE, counter 0, mdu_busy_e = 0; in-flight op discarded.
- MDU op accepted in cycle t: mdu_busy_e high cycles t+1..t+DATA_W; HI/LO update at the edge closing t+DATA_W; MFHI in t+DATA_W+1 returns new value without stall.
- MFHI/MFLO in cycles t+1..t+DATA_W: stall_e high; released in t+DATA_W+1.
- MTHI/MTLO: register updates at the edge closing the accept cycle.
- Back-to-back MDU op: second stalls until mdu_busy_e low, then is accepted.
- All other outputs combinational from current inputs/registers.

## Test plan
- Forwarding, DATA_W=32, FWD_N=3: read_data1=0xFF, fwd sources {0x11,0x22,0x33}, sel_a 0..4 with ADDU, src_b=0 -> results 0xFF,0x11,0x22,0x33,0xFF.
- ADD 0x7FFFFFFF+1 -> 0x80000000, overflow 1; ADDU same -> overflow 0; SUB 5-5 -> zero 1; SRA 0x80000000 shamt 4 -> 0xF8000000.
- MULT -3 × 7 then MFHI/MFLO: busy cycles 1..32, MFHI stalls exactly 32 cycles -> HI 0xFFFFFFFF, LO 0xFFFFFFEB.
- DIV -7/2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; DIVU 7/0 -> LO 0xFFFFFFFF, HI 7.
- Flush MULT in issue cycle -> no busy, HI/LO unchanged; reset_n low mid-RUN -> busy 0, HI=LO=0 immediately.
- DATA_W=16: MULTU 0xFFFF×0xFFFF -> HI 0xFFFE, LO 0x0001 after 16 busy cycles.
